// File: rtl/led_disp_pkg.sv
// Shared 7-segment display definitions: hex glyph table, blank pattern, digit index type.
package led_disp_pkg;

  typedef logic [1:0] digit_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/led_hex_scan_if.sv
// Display data in / multiplexed display pins out for the hex scanner.
// No handshake: value/brightness/blank_lz/dp_mask are level inputs sampled once per
// frame; frame_start is a one-clock event marking the sample; pin outputs are free-running.
interface led_hex_scan_if;
  logic [15:0] value;
  logic [3:0]  brightness;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  com_n;
  logic        frame_start;

  modport master (
    output value, brightness, blank_lz, dp_mask,
    input  seg_n, dp_n, com_n, frame_start
  );

  modport slave (
    input  value, brightness, blank_lz, dp_mask,
    output seg_n, dp_n, com_n, frame_start
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high 7-segment glyph lookup.
module hex_to_seg7
  import led_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG7_HEX[nibble];

endmodule

// File: rtl/led_hex_scan.sv
// Four-digit multiplexed common-anode hex display driver with PWM dimming,
// leading-zero blanking and once-per-frame input latching.
module led_hex_scan
  import led_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 2048,
  parameter int DEAD_CLKS = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  led_hex_scan_if.slave  bus
);

  localparam int PRE_CNT = SCAN_DIV / 16;
  localparam int PRE_W   = $clog2(PRE_CNT);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_CNT - 1);
  localparam logic [PRE_W-1:0] DEAD     = PRE_W'(DEAD_CLKS);

  // Assert asynchronously, release on a clock edge after two flops.
  logic [1:0] rst_sync;
  logic       rst_n_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_i = rst_sync[1];

  logic [PRE_W-1:0] pre;
  logic [3:0]       ph;
  digit_t           dig;
  logic             started;
  logic             pre_wrap, ph_wrap, frame_wrap, latch;

  assign pre_wrap   = (pre == PRE_LAST);
  assign ph_wrap    = pre_wrap && (ph == 4'hF);
  assign frame_wrap = ph_wrap && (dig == 2'd3);
  // The very first clock after release only latches; counting starts from 0 next clock.
  assign latch      = !started || frame_wrap;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre     <= '0;
      ph      <= '0;
      dig     <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (started) begin
        pre <= pre_wrap ? '0 : pre + 1'b1;
        if (pre_wrap) ph  <= ph + 4'd1;
        if (ph_wrap)  dig <= dig + 2'd1;
      end
    end
  end

  logic [15:0] sh_value;
  logic [3:0]  sh_bri;
  logic        sh_blank_lz;
  logic [3:0]  sh_dp;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_value    <= '0;
      sh_bri      <= '0;
      sh_blank_lz <= 1'b0;
      sh_dp       <= '0;
    end else if (latch) begin
      sh_value    <= bus.value;
      sh_bri      <= bus.brightness;
      sh_blank_lz <= bus.blank_lz;
      sh_dp       <= bus.dp_mask;
    end
  end

  logic [3:0] nib;
  logic [6:0] pat;

  assign nib = sh_value[{dig, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nibble (nib),
    .seg    (pat)
  );

  logic       upper_zero, blank, en;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [3:0] com_d;

  always_comb begin
    upper_zero = 1'b0;
    unique case (dig)
      2'd3:    upper_zero = (sh_value[15:12] == 4'h0);
      2'd2:    upper_zero = (sh_value[15:8]  == 8'h00);
      2'd1:    upper_zero = (sh_value[15:4]  == 12'h000);
      default: upper_zero = 1'b0;
    endcase
    blank = sh_blank_lz && upper_zero;
    // Dead time only at the head of a slot, i.e. while ph is 0.
    en    = ((pre >= DEAD) || (ph != 4'h0)) && ((sh_bri == 4'hF) || (ph < sh_bri));
    seg_d = blank ? SEG_OFF : ~pat;
    dp_d  = blank || !sh_dp[dig];
    com_d = en ? ~(4'b0001 << dig) : 4'hF;
    if (!started) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      com_d = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.seg_n       <= SEG_OFF;
      bus.dp_n        <= 1'b1;
      bus.com_n       <= 4'hF;
      bus.frame_start <= 1'b0;
    end else begin
      bus.seg_n       <= seg_d;
      bus.dp_n        <= dp_d;
      bus.com_n       <= com_d;
      bus.frame_start <= latch;
    end
  end

endmodule

// File: tb/tb_led_hex_scan.sv
// Bench for led_hex_scan: directed frames, per-frame expectations queued and
// checked by an independent monitor at each frame boundary.
module tb_led_hex_scan;

  localparam int SCAN_DIV  = 32;
  localparam int DEAD_CLKS = 1;
  localparam int SLOT      = SCAN_DIV;

  typedef struct packed {
    logic [15:0]      tag;
    logic [3:0][6:0]  seg;
    logic [3:0]       dp;
    logic [7:0]       on_cnt;
  } frame_exp_t;

  logic clk;
  logic reset_n;

  led_hex_scan_if bus ();

  led_hex_scan #(.SCAN_DIV(SCAN_DIV), .DEAD_CLKS(DEAD_CLKS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  frame_exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  int         fcount = 0;
  int         off    = 0;
  int         on_cnt   [4];
  int         first_on [4];
  int         seg_bad  [4];
  logic [6:0] seg_seen [4];
  logic       dp_seen  [4];
  int         multi    = 0;
  logic       fs_prev  = 1'b0;

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) begin
      on_cnt[k]   = 0;
      first_on[k] = -1;
      seg_bad[k]  = 0;
      seg_seen[k] = 7'h7F;
      dp_seen[k]  = 1'b1;
    end
    multi = 0;
  endtask

  task automatic sample();
    int lows;
    lows = $countones(~bus.com_n);
    if (lows > 1) multi++;
    else if (lows == 1) begin
      for (int k = 0; k < 4; k++) begin
        if (!bus.com_n[k]) begin
          on_cnt[k]++;
          if (first_on[k] < 0) begin
            first_on[k] = off;
            seg_seen[k] = bus.seg_n;
            dp_seen[k]  = bus.dp_n;
          end else if (seg_seen[k] !== bus.seg_n || dp_seen[k] !== bus.dp_n) begin
            seg_bad[k]++;
          end
        end
      end
    end
  endtask

  task automatic finalise();
    frame_exp_t e;
    while (exp_q.size() > 0 && int'(exp_q[0].tag) < fcount) begin
      e = exp_q.pop_front();
      check($sformatf("frame%0d_missed", e.tag), 0, 1);
    end
    if (exp_q.size() > 0 && int'(exp_q[0].tag) == fcount) begin
      e = exp_q.pop_front();
      check($sformatf("f%0d_onehot", fcount), multi, 0);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("f%0d_on_d%0d", fcount, k), on_cnt[k], int'(e.on_cnt));
        if (e.on_cnt != 0) begin
          check($sformatf("f%0d_first_d%0d", fcount, k), first_on[k], k * SLOT + 2);
          check($sformatf("f%0d_seg_d%0d", fcount, k),
                (seg_bad[k] != 0) ? 'h100 : int'(seg_seen[k]), int'(e.seg[k]));
          check($sformatf("f%0d_dp_d%0d", fcount, k), int'(dp_seen[k]), int'(e.dp[k]));
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      fcount  = 0;
      off     = 0;
      fs_prev = 1'b0;
      clear_stats();
    end else begin
      off++;
      sample();
      if (bus.frame_start) begin
        check("fs_width", int'(fs_prev), 0);
        finalise();
        fcount++;
        off = 0;
        clear_stats();
      end
      fs_prev = bus.frame_start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int tag, input logic [6:0] s3, input logic [6:0] s2,
                          input logic [6:0] s1, input logic [6:0] s0,
                          input logic [3:0] dpn, input int on);
    frame_exp_t e;
    e.tag    = 16'(tag);
    e.seg    = {s3, s2, s1, s0};
    e.dp     = dpn;
    e.on_cnt = 8'(on);
    exp_q.push_back(e);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 400);
    check("frame_timeout", int'(bus.frame_start), 1);
    #2;
  endtask

  task automatic wait_release_fs(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 20);
    check(name, n, 3);
    #2;
  endtask

  task automatic set_frame(input logic [15:0] v, input logic [3:0] bri, input logic blz,
                           input logic [3:0] dpm, input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0,
                           input logic [3:0] dpn, input int on);
    bus.value      = v;
    bus.brightness = bri;
    bus.blank_lz   = blz;
    bus.dp_mask    = dpm;
    push_exp(fcount + 1, s3, s2, s1, s0, dpn, on);
    wait_frame();
  endtask

  task automatic check_dark(input string name);
    check({name, "_seg"}, int'(bus.seg_n), 'h7F);
    check({name, "_com"}, int'(bus.com_n), 'hF);
    check({name, "_dp"},  int'(bus.dp_n), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    bus.value      = 16'h12AF;
    bus.brightness = 4'd15;
    bus.blank_lz   = 1'b0;
    bus.dp_mask    = 4'b0101;
    push_exp(1, 7'h79, 7'h24, 7'h08, 7'h0E, 4'b1010, 31);

    repeat (5) @(negedge clk);
    check_dark("rst_held");
    check("rst_held_fs", int'(bus.frame_start), 0);
    #2 reset_n = 1'b1;
    wait_release_fs("fs_after_release");

    // now at start of frame 1 (12AF on screen); program the following frames
    set_frame(16'h0040, 4'd15, 1'b1, 4'b1111, 7'h7F, 7'h7F, 7'h19, 7'h40, 4'b1100, 31);
    set_frame(16'h0000, 4'd15, 1'b1, 4'b0000, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1111, 31);
    set_frame(16'h0800, 4'd15, 1'b1, 4'b0000, 7'h7F, 7'h00, 7'h40, 7'h40, 4'b1111, 31);
    set_frame(16'h5E3C, 4'd4,  1'b0, 4'b0010, 7'h12, 7'h06, 7'h30, 7'h46, 4'b1101, 7);
    for (int i = 0; i < 3; i++)
      set_frame(16'h1234, 4'd0, 1'b0, 4'b1111, 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 0);
    set_frame(16'h1111, 4'd15, 1'b0, 4'b0000, 7'h79, 7'h79, 7'h79, 7'h79, 4'b1111, 31);

    // frame showing 1111 is running; change value while digit1 is lit
    repeat (40) @(negedge clk);
    #2;
    check("mid_frame_com", int'(bus.com_n), 'hD);
    bus.value = 16'h2222;
    push_exp(fcount + 1, 7'h24, 7'h24, 7'h24, 7'h24, 4'b1111, 31);
    wait_frame();
    wait_frame();

    // asynchronous reset in the middle of a lit slot
    repeat (20) @(negedge clk);
    #2;
    check("pre_reset_com", int'(bus.com_n), 'hE);
    reset_n = 1'b0;
    #1;
    check_dark("rst_async");
    repeat (3) @(negedge clk);
    check_dark("rst_mid_held");
    push_exp(1, 7'h24, 7'h24, 7'h24, 7'h24, 4'b1111, 31);
    #2 reset_n = 1'b1;
    wait_release_fs("fs_after_rst2");
    wait_frame();

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_hex_scan.md
Name: led_hex_scan

Overview:
Downstream consumer of the 16-bit LED PIO output register. It takes the 16-bit `value` and shows it as four hex digits on a common-anode, multiplexed 7-segment display. It also provides PWM brightness control, optional leading-zero blanking and tear-free frame latching. It sits between the Qsys LED PIO `out_port` and the board display pins.

Parameters:
SCAN_DIV, 2048, clocks per digit slot; must be a multiple of 16 and at least 32.
DEAD_CLKS, 2, clocks at the start of each slot with all commons off (ghosting guard); must be less than SCAN_DIV/16.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
value  in  16  display data from the LED PIO out_port; digit0 = value[3:0]
brightness  in  4  on-time in sixteenths; 0 = dark, 15 = fully on
blank_lz  in  1  1 = suppress leading zero digits
dp_mask  in  4  1 = decimal point lit on that digit
seg_n  out  7  segments {g,f,e,d,c,b,a}, active low
dp_n  out  1  decimal point, active low
com_n  out  4  digit commons, active low; com_n[0] = digit0
frame_start  out  1  one-clock pulse when a new frame's shadow value is latched

Behaviour:
- One clock domain, `clk`. `reset_n` is asynchronous and active-low: assertion immediately forces every register to reset; deassertion is synchronised to clk internally.
- Reset values: `seg_n` = 7'h7F, `dp_n` = 1, `com_n` = 4'hF, `frame_start` = 0. Prescaler, PWM phase, digit index, shadow value, shadow brightness, shadow `blank_lz` and shadow `dp_mask` are all 0.
- Prescaler `pre` counts 0..SCAN_DIV/16-1 and wraps. Each wrap increments the 4-bit PWM phase `ph` (0..15, wraps).
- When `ph` wraps 15→0, the 2-bit digit index `dig` advances 0→1→2→3→0.
- Frame latch: on the clock where `dig` wraps 3→0 (and on the first clock after reset release), the inputs are copied into the shadow registers:
  - `value`, `brightness`, `blank_lz` and `dp_mask` are captured together.
  - `frame_start` pulses for exactly that clock.
  - Input changes mid-frame never alter the displayed frame.
- Segment data: the shadow nibble for `dig` goes through hex_to_seg7; `seg_n` is its complement.
  - Hex patterns (active-high, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blanking, when shadow `blank_lz` = 1:
  - Digit k (k = 3..1) is blanked if its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - A blanked digit drives `seg_n` = 7'h7F and `dp_n` = 1; its common still follows PWM.
- Common enable for digit `dig`: active when (`pre` ≥ DEAD_CLKS or `ph` ≠ 0) and (shadow brightness = 15 or `ph` < shadow brightness). Otherwise `com_n` = 4'hF. At most one `com_n` bit is low at any time.
- Latency: all outputs are registered, one clock behind the counter state. `seg_n`, `dp_n` and `com_n` switch on the same edge.
- Boundary: brightness = 0 means `com_n` stays 4'hF forever, but scanning and `frame_start` continue.
- Reset mid-frame: outputs go dark immediately. After release, frame 0 starts with `dig` = 0 and a fresh latch.

Decomposition:
- Package led_disp_pkg holds:
  - the 16-entry SEG7_HEX constant table;
  - the SEG_OFF = 7'h7F constant;
  - a digit_t (2-bit) typedef.
- Sub-module hex_to_seg7: combinational nibble→7-bit pattern from SEG7_HEX. It is reused by other display blocks.

Test Plan:
Use SCAN_DIV = 32 and DEAD_CLKS = 1 throughout.
1. Reset held, then released → `seg_n` = 7F, `com_n` = F while reset is held; `frame_start` pulses on the first clock after release; `com_n` then cycles E,D,B,7 with a 32-clock slot period.
2. `value` = 16'h12AF, brightness = 15, blank_lz = 0 → digit0 `seg_n` = ~71 = 0E, digit1 ~77 = 08, digit2 ~5B = 24, digit3 ~06 = 79. Each common is low 31 of 32 clocks (one dead clock).
3. `value` = 16'h0040, blank_lz = 1 → digits 3 and 2 show `seg_n` = 7F, digit1 shows ~66 = 19, digit0 shows ~3F = 40. With `value` = 0, only digit0 shows 40.
4. brightness = 4 → each digit's common is low only while `ph` < 4 (8 clocks per 32-clock slot, minus the dead clock). brightness = 0 → `com_n` stays F across 3 frames.
5. Change `value` from 16'h1111 to 16'h2222 while digit1 is active → the rest of the current frame still shows "1"; "2" appears only after the next `frame_start`.
6. Assert `reset_n` low for 3 clocks mid-slot → `com_n` = F and `seg_n` = 7F asynchronously within the same clock; after release, scanning restarts at digit0 with a new `frame_start`.
